periph_timer: RTL and testbench

Memory-mapped 32-bit timer that sits on the peripheral side of a crossbar peripheral port and answers its req/addr/wen/wdata/be/ready protocol. It provides:
- a free-running or auto-reloading counter with an optional prescaler;
- a compare-match status flag;
- a level interrupt.

Register reads return data one cycle after acceptance.

---
 rtl/periph_timer.sv | 127 ++++++++++++
 tb/tb_periph_timer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/periph_timer.sv
// Memory-mapped 32-bit timer with compare match, auto-reload and level interrupt.
// Optional prescaler enabled by defining PERIPH_TIMER_PRESCALER_EN.
module periph_timer #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  wen_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            be_i,
    output logic                  ready_o,
    output logic [31:0]           rdata_o,
    output logic                  irq_o
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_COUNT    = 3'd1;
    localparam logic [2:0] OFF_COMPARE  = 3'd2;
    localparam logic [2:0] OFF_PRESCALE = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] wd,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    logic       accept, wr, rd;
    logic [2:0] off;
    logic       wr_ctrl, wr_count, wr_compare, wr_status;
    logic [2:0]  ctrl_q;
    logic [31:0] count_q, compare_q;
    logic        match_q;
    logic        en, irq_en, auto_reload;
    logic        tick, hit;
    logic [31:0] rd_mux;

    assign ready_o    = ~rst_i;
    assign accept     = req_i & ready_o;
    assign off        = addr_i[2:0];
    assign wr         = accept & wen_i;
    assign rd         = accept & ~wen_i;
    assign wr_ctrl    = wr && (off == OFF_CTRL);
    assign wr_count   = wr && (off == OFF_COUNT);
    assign wr_compare = wr && (off == OFF_COMPARE);
    assign wr_status  = wr && (off == OFF_STATUS);

    generate
        if (ADDR_WIDTH > 3) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr_i[ADDR_WIDTH-1:3];
        end
    endgenerate

    assign en          = ctrl_q[0];
    assign irq_en      = ctrl_q[1];
    assign auto_reload = ctrl_q[2];
    assign hit         = (count_q == compare_q);
    assign irq_o       = match_q & irq_en;

`ifdef PERIPH_TIMER_PRESCALER_EN
    logic        wr_prescale;
    logic [31:0] prescale_q, pre_cnt_q;

    assign wr_prescale = wr && (off == OFF_PRESCALE);
    assign tick        = en && (pre_cnt_q == prescale_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prescale_q <= '0;
            pre_cnt_q  <= '0;
        end else begin
            if (wr_prescale) prescale_q <= merge(prescale_q, wdata_i, be_i);
            // Reconfiguration restarts the prescale period from zero
            if (!en || wr_ctrl || wr_prescale || tick) pre_cnt_q <= '0;
            else                                       pre_cnt_q <= pre_cnt_q + 32'd1;
        end
    end
`else
    assign tick = en;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= '1;
            match_q   <= 1'b0;
            rdata_o   <= '0;
        end else begin
            if (wr_ctrl && be_i[0]) ctrl_q <= wdata_i[2:0];
            if (wr_compare) compare_q <= merge(compare_q, wdata_i, be_i);

            if (wr_count)                  count_q <= merge(count_q, wdata_i, be_i);
            else if (tick && hit && auto_reload) count_q <= '0;
            else if (tick)                 count_q <= count_q + 32'd1;

            // Hardware set has priority over software clear
            if (tick && hit)                                match_q <= 1'b1;
            else if (wr_status && be_i[0] && wdata_i[0])    match_q <= 1'b0;

            if (rd) rdata_o <= rd_mux;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_CTRL:     rd_mux = {29'd0, ctrl_q};
            OFF_COUNT:    rd_mux = count_q;
            OFF_COMPARE:  rd_mux = compare_q;
`ifdef PERIPH_TIMER_PRESCALER_EN
            OFF_PRESCALE: rd_mux = prescale_q;
`endif
            OFF_STATUS:   rd_mux = {31'd0, match_q};
            default:      rd_mux = '0;
        endcase
    end

endmodule

// File: tb/tb_periph_timer.sv
// Self-checking bench for periph_timer: register table vectors plus counting,
// collision, wrap and asynchronous reset sequences.
module tb_periph_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [3:0]  addr = '0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        ready;
    logic [31:0] rdata;
    logic        irq;

    int total  = 0;
    int passed = 0;

`ifdef PERIPH_TIMER_PRESCALER_EN
    localparam logic [31:0] PRE5 = 32'd5;
`else
    localparam logic [31:0] PRE5 = 32'd0;
`endif

    periph_timer #(.ADDR_WIDTH(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .addr_i  (addr),
        .wen_i   (wen),
        .wdata_i (wdata),
        .be_i    (be),
        .ready_o (ready),
        .rdata_o (rdata),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic bus_op(input logic [3:0] a, input logic w, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; addr = a; wen = w; wdata = d; be = b;
        @(posedge clk);
        #1;
        req = 1'b0; wen = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{4'd0, 1'b0, 32'h0,        4'h0, 32'h0};
        vecs[1]  = '{4'd1, 1'b0, 32'h0,        4'h0, 32'h0};
        vecs[2]  = '{4'd2, 1'b0, 32'h0,        4'h0, 32'hFFFFFFFF};
        vecs[3]  = '{4'd3, 1'b0, 32'h0,        4'h0, 32'h0};
        vecs[4]  = '{4'd4, 1'b0, 32'h0,        4'h0, 32'h0};
        vecs[5]  = '{4'd5, 1'b0, 32'h0,        4'h0, 32'h0};
        vecs[6]  = '{4'd6, 1'b0, 32'h0,        4'h0, 32'h0};
        vecs[7]  = '{4'd7, 1'b0, 32'h0,        4'h0, 32'h0};
        vecs[8]  = '{4'd2, 1'b1, 32'hAABBCCDD, 4'h5, 32'h0};
        vecs[9]  = '{4'd2, 1'b0, 32'h0,        4'h0, 32'hFFBBFFDD};
        vecs[10] = '{4'd2, 1'b1, 32'h0,        4'h0, 32'hFFBBFFDD};
        vecs[11] = '{4'd2, 1'b0, 32'h0,        4'h0, 32'hFFBBFFDD};
        vecs[12] = '{4'd3, 1'b1, 32'h5,        4'hF, 32'hFFBBFFDD};
        vecs[13] = '{4'd3, 1'b0, 32'h0,        4'h0, PRE5};
        vecs[14] = '{4'd0, 1'b1, 32'hFFFFFFF8, 4'hF, PRE5};
        vecs[15] = '{4'd0, 1'b0, 32'h0,        4'h0, 32'h0};
        vecs[16] = '{4'd6, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[17] = '{4'd6, 1'b0, 32'h0,        4'h0, 32'h0};
        vecs[18] = '{4'd3, 1'b1, 32'h0,        4'hF, 32'h0};
        vecs[19] = '{4'd2, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[20] = '{4'd2, 1'b0, 32'h0,        4'h0, 32'hFFFFFFFF};
        vecs[21] = '{4'd4, 1'b0, 32'h0,        4'h0, 32'h0};

        // Reset state
        #1;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq",   {31'd0, irq},   32'd0);
        idle();
        idle();
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, ready}, 32'd1);

        // Register map table
        for (int i = 0; i < 22; i++) begin
            bus_op(vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].be);
            check($sformatf("vec%0d", i), rdata, vecs[i].exp);
        end

        // Auto-reload match and interrupt
        begin
            logic [31:0] exp_cnt [5];
            logic        exp_irq [5];
            exp_cnt = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
            exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            bus_op(4'd2, 1'b1, 32'd3, 4'hF);
            bus_op(4'd3, 1'b1, 32'd0, 4'hF);
            bus_op(4'd0, 1'b1, 32'd7, 4'hF);
            for (int i = 0; i < 5; i++) begin
                bus_op(4'd1, 1'b0, 32'd0, 4'h0);
                check($sformatf("ar_count%0d", i), rdata, exp_cnt[i]);
                check($sformatf("ar_irq%0d", i), {31'd0, irq}, {31'd0, exp_irq[i]});
            end
        end
        bus_op(4'd4, 1'b1, 32'd1, 4'hF);
        check("w1c_irq_drop", {31'd0, irq}, 32'd0);
        idle();
        bus_op(4'd4, 1'b1, 32'd1, 4'hF);
        check("w1c_vs_match_irq", {31'd0, irq}, 32'd1);
        bus_op(4'd4, 1'b0, 32'd0, 4'h0);
        check("w1c_vs_match_status", rdata, 32'd1);
        bus_op(4'd0, 1'b1, 32'd0, 4'hF);
        bus_op(4'd4, 1'b1, 32'd1, 4'hF);
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // Prescaler
        bus_op(4'd1, 1'b1, 32'd0, 4'hF);
        bus_op(4'd2, 1'b1, 32'hFFFFFFFF, 4'hF);
        bus_op(4'd3, 1'b1, 32'd4, 4'hF);
        bus_op(4'd0, 1'b1, 32'd1, 4'hF);
`ifdef PERIPH_TIMER_PRESCALER_EN
        repeat (4) idle();
        bus_op(4'd1, 1'b0, 32'd0, 4'h0);
        check("pre_cnt_c4", rdata, 32'd0);
        bus_op(4'd1, 1'b0, 32'd0, 4'h0);
        check("pre_cnt_c5", rdata, 32'd1);
        repeat (3) idle();
        bus_op(4'd1, 1'b0, 32'd0, 4'h0);
        check("pre_cnt_c9", rdata, 32'd1);
        bus_op(4'd1, 1'b0, 32'd0, 4'h0);
        check("pre_cnt_c10", rdata, 32'd2);
`else
        bus_op(4'd1, 1'b0, 32'd0, 4'h0);
        check("nopre_cnt0", rdata, 32'd0);
        bus_op(4'd1, 1'b0, 32'd0, 4'h0);
        check("nopre_cnt1", rdata, 32'd1);
        bus_op(4'd1, 1'b0, 32'd0, 4'h0);
        check("nopre_cnt2", rdata, 32'd2);
        bus_op(4'd3, 1'b0, 32'd0, 4'h0);
        check("nopre_prescale", rdata, 32'd0);
`endif

        // COUNT write collides with a tick
        bus_op(4'd3, 1'b1, 32'd0, 4'hF);
        bus_op(4'd1, 1'b1, 32'h100, 4'hF);
        bus_op(4'd1, 1'b0, 32'd0, 4'h0);
        check("count_write_wins", rdata, 32'h100);
        bus_op(4'd1, 1'b0, 32'd0, 4'h0);
        check("count_after_write", rdata, 32'h101);

        // Wrap without match
        bus_op(4'd0, 1'b1, 32'd0, 4'hF);
        bus_op(4'd3, 1'b1, 32'd0, 4'hF);
        bus_op(4'd2, 1'b1, 32'd5, 4'hF);
        bus_op(4'd4, 1'b1, 32'd1, 4'hF);
        bus_op(4'd1, 1'b1, 32'hFFFFFFFE, 4'hF);
        bus_op(4'd0, 1'b1, 32'd1, 4'hF);
        begin
            logic [31:0] exp_w [4];
            exp_w = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'd1};
            for (int i = 0; i < 4; i++) begin
                bus_op(4'd1, 1'b0, 32'd0, 4'h0);
                check($sformatf("wrap%0d", i), rdata, exp_w[i]);
            end
        end
        bus_op(4'd4, 1'b0, 32'd0, 4'h0);
        check("wrap_no_match", rdata, 32'd0);

        // Asynchronous reset mid-count with a write pending
        bus_op(4'd2, 1'b0, 32'd0, 4'h0);
        check("pre_reset_rdata", rdata, 32'd5);
        bus_op(4'd0, 1'b1, 32'd3, 4'hF);
        req = 1'b1; wen = 1'b1; addr = 4'd2; wdata = 32'h12; be = 4'hF;
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", {31'd0, ready}, 32'd0);
        check("arst_rdata", rdata, 32'd0);
        check("arst_count", dut.count_q, 32'd0);
        check("arst_compare", dut.compare_q, 32'hFFFFFFFF);
        check("arst_ctrl", {29'd0, dut.ctrl_q}, 32'd0);
        idle();
        req = 1'b0; wen = 1'b0;
        rst = 1'b0;
        bus_op(4'd2, 1'b0, 32'd0, 4'h0);
        check("post_rst_compare", rdata, 32'hFFFFFFFF);
        bus_op(4'd0, 1'b0, 32'd0, 4'h0);
        check("post_rst_ctrl", rdata, 32'd0);
        bus_op(4'd1, 1'b0, 32'd0, 4'h0);
        check("post_rst_count", rdata, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
